// File: rtl/spi_deserializer.sv
// SPI receive stage: edge-detects sclk on clk, rebuilds MSB-first words and strobes them into the RX FIFO.
// Optional feature macro: SPI_DESER_RX_COUNT_EN adds the rx_count accepted-word counter output.
module spi_deserializer #(
    parameter  int unsigned DATA_WIDTH = 8,
    localparam int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  done,
    input  logic                  full,
    input  logic                  clr_status,
    output logic                  write_en,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  busy,
    output logic                  overflow,
    output logic                  frame_err
`ifdef SPI_DESER_RX_COUNT_EN
    ,
    output logic [15:0]           rx_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_sclk_q;
    logic                    w_rise;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic [CNT_WIDTH-1:0]    w_cnt_nxt;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [DATA_WIDTH-1:0]   w_shift_nxt;
    logic [DATA_WIDTH-1:0]   w_shifted;
    logic                    w_last;
    logic                    w_enter_write;

    logic                    r_write_en;
    logic [DATA_WIDTH-1:0]   r_write_data;
    logic                    r_busy;
    logic                    r_overflow;
    logic                    r_frame_err;
    logic                    w_write_en_nxt;
    logic [DATA_WIDTH-1:0]   w_write_data_nxt;
    logic                    w_drop;
    logic                    w_frame_err_nxt;

    assign w_rise        = sclk & ~r_sclk_q;
    assign w_shifted     = DATA_WIDTH'({r_shift, mosi});
    assign w_last        = (r_cnt == CNT_WIDTH'(DATA_WIDTH - 1));
    assign w_enter_write = (w_state_nxt == S_WRITE);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = (DATA_WIDTH == 1) ? S_WRITE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_rise && w_last) begin
                    w_state_nxt = S_WRITE;
                end else if (done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WRITE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and output next values; the accept/drop decision is taken on entry to WRITE
    always_comb begin
        w_cnt_nxt        = r_cnt;
        w_shift_nxt      = r_shift;
        w_write_en_nxt   = 1'b0;
        w_write_data_nxt = r_write_data;
        w_drop           = 1'b0;
        w_frame_err_nxt  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_shift_nxt = w_shifted;
                    w_cnt_nxt   = CNT_WIDTH'(1);
                end
            end
            S_SHIFT: begin
                if (done && !(w_rise && w_last)) begin
                    w_shift_nxt     = '0;
                    w_cnt_nxt       = '0;
                    w_frame_err_nxt = 1'b1;
                end else if (w_rise) begin
                    w_shift_nxt = w_shifted;
                    w_cnt_nxt   = CNT_WIDTH'(r_cnt + CNT_WIDTH'(1));
                end
            end
            S_WRITE: begin
                w_shift_nxt = '0;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_shift_nxt = '0;
                w_cnt_nxt   = '0;
            end
        endcase
        if (w_enter_write) begin
            w_shift_nxt = '0;
            w_cnt_nxt   = '0;
            if (full) begin
                w_drop = 1'b1;
            end else begin
                w_write_en_nxt   = 1'b1;
                w_write_data_nxt = w_shifted;
            end
        end
    end

    // Registered datapath and outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sclk_q     <= 1'b1;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_write_en   <= 1'b0;
            r_write_data <= '0;
            r_busy       <= 1'b0;
            r_overflow   <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_sclk_q     <= sclk;
            r_cnt        <= w_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_write_en   <= w_write_en_nxt;
            r_write_data <= w_write_data_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_frame_err  <= w_frame_err_nxt;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_status) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign write_en   = r_write_en;
    assign write_data = r_write_data;
    assign busy       = r_busy;
    assign overflow   = r_overflow;
    assign frame_err  = r_frame_err;

`ifdef SPI_DESER_RX_COUNT_EN
    logic [15:0] r_rx_count;

    // Accepted-word counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_count <= '0;
        end else if (r_write_en) begin
            r_rx_count <= r_rx_count + 16'd1;
        end
    end

    assign rx_count = r_rx_count;
`endif

endmodule

// File: tb/tb_spi_deserializer.sv
// Randomized self-checking bench for spi_deserializer against a word-level reference model.
module tb_spi_deserializer;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          sclk;
    logic          mosi;
    logic          done;
    logic          full;
    logic          clr_status;
    logic          write_en;
    logic [DW-1:0] write_data;
    logic          busy;
    logic          overflow;
    logic          frame_err;
`ifdef SPI_DESER_RX_COUNT_EN
    logic [15:0]   rx_count;
`endif

    int            n_vec = 0;
    int            n_err = 0;

    // Reference model state
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] act_q[$];
    bit            exp_ovf = 1'b0;
    int            exp_rx = 0;
    int            exp_ferr = 0;
    int            ferr_cnt = 0;
    int            b2b_cnt = 0;
    bit            prev_we = 1'b0;

    always #5 clk = ~clk;

    spi_deserializer #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .mosi       (mosi),
        .done       (done),
        .full       (full),
        .clr_status (clr_status),
        .write_en   (write_en),
        .write_data (write_data),
        .busy       (busy),
        .overflow   (overflow),
        .frame_err  (frame_err)
`ifdef SPI_DESER_RX_COUNT_EN
        ,
        .rx_count   (rx_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Passive monitor: record every accepted word and frame error
    always @(negedge clk) begin
        if (rst) begin
            if (write_en) act_q.push_back(write_data);
            if (write_en && prev_we) b2b_cnt++;
            if (frame_err) ferr_cnt++;
            prev_we = write_en;
        end else begin
            prev_we = 1'b0;
        end
    end

    // Called at a negedge; returns right after raising sclk for bit n-1
    task automatic drive_bits(input logic [DW-1:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            int kl;
            int kh;
            kl = $urandom_range(1, 3);
            kh = $urandom_range(1, 3);
            sclk = 1'b0;
            mosi = w[DW-1-i];
            repeat (kl) @(negedge clk);
            sclk = 1'b1;
            if (i != n - 1) repeat (kh) @(negedge clk);
        end
    endtask

    // dm: 0 no done, 1 done with completing rise, 2 done during WRITE
    task automatic send_word(input logic [DW-1:0] w, input bit fl, input int dm, input bit clr_last);
        full = fl;
        drive_bits(w, DW);
        done       = (dm == 1);
        clr_status = clr_last;
        if (fl) exp_ovf = 1'b1;
        else begin
            exp_q.push_back(w);
            exp_rx++;
        end
        @(negedge clk);
        done       = (dm == 2);
        clr_status = 1'b0;
        check("wr_latency", write_en, !fl);
        if (!fl) check("wr_data", write_data, w);
        check("busy_write", busy, 1);
        @(negedge clk);
        done = 1'b0;
        full = 1'b0;
        check("wr_single", write_en, 0);
        check("busy_idle", busy, 0);
        check("overflow", overflow, exp_ovf);
        check("no_ferr", frame_err, 0);
`ifdef SPI_DESER_RX_COUNT_EN
        check("rx_count", rx_count, exp_rx);
`endif
    endtask

    task automatic send_partial(input logic [DW-1:0] w, input int n);
        drive_bits(w, n);
        repeat ($urandom_range(1, 3)) @(negedge clk);
        done = 1'b1;
        exp_ferr++;
        @(negedge clk);
        done = 1'b0;
        check("ferr_pulse", frame_err, 1);
        check("ferr_busy", busy, 0);
        @(negedge clk);
        check("ferr_once", frame_err, 0);
    endtask

    task automatic clear_status();
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        exp_ovf = 1'b0;
        @(negedge clk);
        check("ovf_clear", overflow, exp_ovf);
    endtask

    task automatic check_reset_outputs();
        check("rst_we", write_en, 0);
        check("rst_wd", write_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        check("rst_ferr", frame_err, 0);
`ifdef SPI_DESER_RX_COUNT_EN
        check("rst_rxc", rx_count, 0);
`endif
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        sclk       = 1'b1;
        mosi       = 1'b0;
        done       = 1'b0;
        full       = 1'b0;
        clr_status = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);

        send_word(8'hA5, 1'b0, 0, 1'b0);
        send_word(8'h3C, 1'b0, 1, 1'b0);
        send_word(8'hFF, 1'b0, 2, 1'b0);
        send_word(8'h81, 1'b1, 0, 1'b1);
        clear_status();
        send_partial(8'hC3, 5);
        send_word(8'h5A, 1'b0, 0, 1'b0);

        // Reset mid-word, then a clean word
        drive_bits(8'hE7, 4);
        rst = 1'b0;
        #1;
        check_reset_outputs();
        exp_ovf = 1'b0;
        exp_rx  = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_no_edge", busy, 0);
        send_word(8'h0F, 1'b0, 0, 1'b0);

`ifdef SPI_DESER_RX_COUNT_EN
        send_word(8'h11, 1'b0, 0, 1'b0);
        send_word(8'h22, 1'b1, 0, 1'b0);
        send_word(8'h33, 1'b0, 0, 1'b0);
        check("rx_count_3", rx_count, 3);
        clear_status();
`endif

        for (int it = 0; it < 40; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                send_partial(DW'($urandom), $urandom_range(1, DW - 1));
            end else if (r == 1) begin
                clear_status();
            end else begin
                bit fl;
                fl = ($urandom_range(0, 3) == 0);
                send_word(DW'($urandom), fl, $urandom_range(0, 2), fl && $urandom_range(0, 1) == 1);
            end
        end

        repeat (3) @(negedge clk);
        check("word_count", act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            check("word_order", act_q[i], exp_q[i]);
        end
        check("back_to_back", b2b_cnt, 0);
        check("ferr_count", ferr_cnt, exp_ferr);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
